// File: rtl/axi_emif_mem_responder_if.sv
// AXI4 memory-mapped bus between a user-side master and the EMIF memory responder.
// Widths must match the parameters of the responder attached to the slave modport.
interface axi_emif_mem_responder_if #(
  parameter int ID_WIDTH   = 9,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int USER_WIDTH = 1
);
  logic                    awvalid;
  logic                    awready;
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [USER_WIDTH-1:0]   awuser;

  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic [USER_WIDTH-1:0]   buser;

  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [USER_WIDTH-1:0]   aruser;

  logic                    rvalid;
  logic                    rready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [USER_WIDTH-1:0]   ruser;

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst, awuser,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp, buser,
    output bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, aruser,
    input  arready,
    input  rvalid, rid, rdata, rresp, rlast, ruser,
    output rready
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst, awuser,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp, buser,
    input  bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, aruser,
    output arready,
    output rvalid, rid, rdata, rresp, rlast, ruser,
    input  rready
  );
endinterface

// File: rtl/axi_emif_mem_responder.sv
// AXI4 memory responder standing in for the EMIF controller: independent write and
// read FSMs, one burst each in flight, backed by a word array that is never reset.
module axi_emif_mem_responder #(
  parameter int ID_WIDTH       = 9,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 256,
  parameter int USER_WIDTH     = 1,
  parameter int MEM_DEPTH_LOG2 = 8
) (
  input logic                     clk,
  input logic                     rst,
  axi_emif_mem_responder_if.slave axi
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFF        = $clog2(STRB_WIDTH);
  localparam int DEPTH      = 1 << MEM_DEPTH_LOG2;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [MEM_DEPTH_LOG2-1:0] index_t;
  typedef logic [ADDR_WIDTH-1:0]     addr_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t              w_state;
  index_t                w_index;
  logic [7:0]            w_count;
  logic [7:0]            w_len;
  logic                  w_incr;
  logic                  w_err;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [1:0]            bresp_q;
  logic [USER_WIDTH-1:0] buser_q;

  r_state_t              r_state;
  index_t                r_index;
  logic [7:0]            r_count;
  logic [7:0]            r_len;
  logic                  r_incr;
  logic                  r_err;
  logic                  arready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [1:0]            rresp_q;
  logic [USER_WIDTH-1:0] ruser_q;

  logic w_fire;
  logic w_last_beat;
  logic w_beat_err;

  // Beat size and upper address bits play no part in addressing.
  logic  unused_ok;
  addr_t unused_addr;
  assign unused_ok   = ^{axi.awsize, axi.arsize};
  assign unused_addr = axi.awaddr ^ axi.araddr;

  assign w_fire      = axi.wvalid && wready_q;
  assign w_last_beat = (w_count == w_len);
  assign w_beat_err  = w_err || (axi.wlast != w_last_beat);

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;
  assign axi.buser   = buser_q;

  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rlast   = rlast_q;
  assign axi.rid     = rid_q;
  assign axi.rresp   = rresp_q;
  assign axi.ruser   = ruser_q;
  assign axi.rdata   = r_err ? '0 : mem[r_index];

  // Writes landing on the reset cycle are dropped so an aborted burst leaves later words intact.
  always_ff @(posedge clk) begin
    if (!rst && w_fire && !w_err) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (axi.wstrb[b]) mem[w_index][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      w_index   <= '0;
      w_count   <= '0;
      w_len     <= '0;
      w_incr    <= 1'b0;
      w_err     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      buser_q   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (axi.awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= axi.awid;
            buser_q   <= axi.awuser;
            w_index   <= axi.awaddr[OFF +: MEM_DEPTH_LOG2];
            w_len     <= axi.awlen;
            w_count   <= '0;
            w_incr    <= (axi.awburst == BURST_INCR);
            w_err     <= axi.awburst[1];
            w_state   <= W_DATA;
          end
        end
        // The burst length comes from awlen alone; wlast only feeds the error flag.
        W_DATA: begin
          if (w_fire) begin
            w_err   <= w_beat_err;
            w_count <= w_count + 8'd1;
            if (w_incr) w_index <= w_index + 1'b1;
            if (w_last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= w_beat_err ? RESP_SLVERR : RESP_OKAY;
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bvalid_q && axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // rlast is precomputed one beat ahead so it is a plain register at the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      r_index   <= '0;
      r_count   <= '0;
      r_len     <= '0;
      r_incr    <= 1'b0;
      r_err     <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= RESP_OKAY;
      ruser_q   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (axi.arvalid && arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rlast_q   <= (axi.arlen == 8'd0);
            rid_q     <= axi.arid;
            ruser_q   <= axi.aruser;
            rresp_q   <= axi.arburst[1] ? RESP_SLVERR : RESP_OKAY;
            r_err     <= axi.arburst[1];
            r_incr    <= (axi.arburst == BURST_INCR);
            r_index   <= axi.araddr[OFF +: MEM_DEPTH_LOG2];
            r_len     <= axi.arlen;
            r_count   <= '0;
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid_q && axi.rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_count <= r_count + 8'd1;
              rlast_q <= ((r_count + 8'd1) == r_len);
              if (r_incr) r_index <= r_index + 1'b1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_emif_mem_responder.sv
// Randomized scoreboard bench for axi_emif_mem_responder: a word-array model predicts
// every B and R beat, and a negedge monitor pops and compares them as the DUT presents them.
module tb_axi_emif_mem_responder;
  localparam int ID_WIDTH       = 9;
  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 256;
  localparam int USER_WIDTH     = 1;
  localparam int MEM_DEPTH_LOG2 = 8;
  localparam int DEPTH          = 1 << MEM_DEPTH_LOG2;
  localparam int STRB_WIDTH     = DATA_WIDTH / 8;
  localparam int OFF            = $clog2(STRB_WIDTH);
  localparam int TIMEOUT        = 100;

  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;
  localparam logic [1:0] RSVD  = 2'b11;

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [STRB_WIDTH-1:0] strb_t;
  typedef logic [ID_WIDTH-1:0]   id_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [USER_WIDTH-1:0] user_t;

  typedef struct {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_exp_t;

  typedef struct {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
    bit         check_data;
  } r_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_emif_mem_responder_if #(
    .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .USER_WIDTH(USER_WIDTH)
  ) bus ();

  axi_emif_mem_responder #(
    .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .USER_WIDTH(USER_WIDTH), .MEM_DEPTH_LOG2(MEM_DEPTH_LOG2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .axi(bus)
  );

  data_t  model_mem   [DEPTH];
  bit     model_valid [DEPTH];
  b_exp_t b_q[$];
  r_exp_t r_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int r_beats = 0;
  int r_first_cyc = 0;
  int r_last_cyc = 0;
  int w_wait_cycles = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input data_t actual, input data_t expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no handshake within bound, expected one", name);
  endtask

  function automatic data_t rand_word();
    data_t w;
    for (int i = 0; i < DATA_WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic strb_t rand_strb();
    strb_t s;
    for (int i = 0; i < STRB_WIDTH; i++) s[i] = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // Monitor: handshakes are decided by values stable from posedge+1 to the next posedge.
  initial begin
    r_exp_t     re;
    b_exp_t     be;
    bit         r_stall_prev = 0;
    bit         b_stall_prev = 0;
    data_t      rdata_prev;
    logic [12:0] rfields_prev;
    logic [11:0] bfields_prev;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_stall_prev = 0;
        b_stall_prev = 0;
      end else begin
        if (r_stall_prev) begin
          checkOutput("r_hold_valid", data_t'(bus.rvalid), data_t'(1'b1));
          checkOutput("r_hold_fields", data_t'({bus.rid, bus.rresp, bus.rlast, bus.ruser}), data_t'(rfields_prev));
          checkOutput("r_hold_data", bus.rdata, rdata_prev);
        end
        if (b_stall_prev) begin
          checkOutput("b_hold_valid", data_t'(bus.bvalid), data_t'(1'b1));
          checkOutput("b_hold_fields", data_t'({bus.bid, bus.bresp, bus.buser}), data_t'(bfields_prev));
          checkOutput("b_hold_awready", data_t'(bus.awready), data_t'(1'b0));
        end
        if (bus.rvalid && bus.rready) begin
          if (r_q.size() == 0) begin
            reportTimeout("r_unexpected_beat");
          end else begin
            re = r_q.pop_front();
            checkOutput("r_fields", data_t'({bus.rid, bus.rresp, bus.rlast, bus.ruser}),
                        data_t'({re.id, re.resp, re.last, re.user}));
            if (re.check_data) checkOutput("r_data", bus.rdata, re.data);
          end
          if (r_beats == 0) r_first_cyc = cyc;
          r_last_cyc = cyc;
          r_beats++;
        end
        if (bus.bvalid && bus.bready) begin
          if (b_q.size() == 0) begin
            reportTimeout("b_unexpected_response");
          end else begin
            be = b_q.pop_front();
            checkOutput("b_fields", data_t'({bus.bid, bus.bresp, bus.buser}),
                        data_t'({be.id, be.resp, be.user}));
          end
        end
        r_stall_prev = bus.rvalid && !bus.rready;
        rdata_prev   = bus.rdata;
        rfields_prev = {bus.rid, bus.rresp, bus.rlast, bus.ruser};
        b_stall_prev = bus.bvalid && !bus.bready;
        bfields_prev = {bus.bid, bus.bresp, bus.buser};
      end
    end
  end

  task automatic write_burst(input id_t id, input addr_t addr, input int len, input logic [1:0] burst,
                             input user_t user, input bit rnd_data, input data_t fixed_data,
                             input bit rnd_strb, input strb_t fixed_strb,
                             input int bad_last_beat, input int rst_beat);
    int    base;
    int    cur;
    int    t;
    bit    err;
    bit    wl;
    data_t d;
    strb_t s;
    base = int'(addr[OFF +: MEM_DEPTH_LOG2]);
    err  = burst[1];
    @(posedge clk); #1;
    bus.awvalid = 1'b1;
    bus.awid    = id;
    bus.awaddr  = addr;
    bus.awlen   = 8'(len);
    bus.awsize  = 3'(OFF);
    bus.awburst = burst;
    bus.awuser  = user;
    t = 0;
    @(negedge clk);
    while (!bus.awready && t < TIMEOUT) begin @(negedge clk); t++; end
    if (!bus.awready) begin reportTimeout("aw_handshake"); bus.awvalid = 1'b0; return; end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      d  = rnd_data ? rand_word() : fixed_data;
      s  = rnd_strb ? rand_strb() : fixed_strb;
      wl = (b == len) ^ (b == bad_last_beat);
      bus.wvalid = 1'b1;
      bus.wdata  = d;
      bus.wstrb  = s;
      bus.wlast  = wl;
      if (b == rst_beat) rst = 1'b1;
      t = 0;
      @(negedge clk);
      if (b == 0) checkOutput("aw_to_wready_latency", data_t'(bus.wready), data_t'(1'b1));
      while (!bus.wready && t < TIMEOUT) begin @(negedge clk); t++; end
      w_wait_cycles += t;
      if (!bus.wready) begin reportTimeout("w_handshake"); bus.wvalid = 1'b0; return; end
      if (b == rst_beat) begin
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        @(negedge clk);
        checkOutput("midburst_reset_outputs",
                    data_t'({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_reset_awready", data_t'(bus.awready), data_t'(1'b1));
        checkOutput("post_reset_arready", data_t'(bus.arready), data_t'(1'b1));
        return;
      end
      cur = (base + ((burst == INCR) ? b : 0)) % DEPTH;
      if (!err && (wl != (b == len))) begin
        err = 1'b1;
        model_valid[cur] = 1'b0;
      end else if (!err) begin
        for (int k = 0; k < STRB_WIDTH; k++) if (s[k]) model_mem[cur][k*8 +: 8] = d[k*8 +: 8];
        if (&s) model_valid[cur] = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    b_q.push_back('{id: id, resp: (err ? 2'b10 : 2'b00), user: user});
    @(negedge clk);
    checkOutput("w_to_bvalid_latency", data_t'(bus.bvalid), data_t'(1'b1));
  endtask

  task automatic read_burst(input id_t id, input addr_t addr, input int len, input logic [1:0] burst,
                            input user_t user);
    int     base;
    int     cur;
    int     t;
    r_exp_t re;
    base = int'(addr[OFF +: MEM_DEPTH_LOG2]);
    @(posedge clk); #1;
    bus.arvalid = 1'b1;
    bus.arid    = id;
    bus.araddr  = addr;
    bus.arlen   = 8'(len);
    bus.arsize  = 3'(OFF);
    bus.arburst = burst;
    bus.aruser  = user;
    t = 0;
    @(negedge clk);
    while (!bus.arready && t < TIMEOUT) begin @(negedge clk); t++; end
    if (!bus.arready) begin reportTimeout("ar_handshake"); bus.arvalid = 1'b0; return; end
    for (int b = 0; b <= len; b++) begin
      cur           = (base + ((burst == INCR) ? b : 0)) % DEPTH;
      re.id         = id;
      re.resp       = burst[1] ? 2'b10 : 2'b00;
      re.data       = burst[1] ? '0 : model_mem[cur];
      re.last       = (b == len);
      re.user       = user;
      re.check_data = burst[1] || model_valid[cur];
      r_q.push_back(re);
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(negedge clk);
    checkOutput("ar_to_rvalid_latency", data_t'(bus.rvalid), data_t'(1'b1));
  endtask

  task automatic drain();
    int t = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && t < 2000) begin @(negedge clk); t++; end
    if (b_q.size() != 0 || r_q.size() != 0) begin
      reportTimeout("drain_scoreboard");
      b_q.delete();
      r_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus();
    logic [1:0] kinds [5];
    logic [1:0] bt;
    kinds[0] = FIXED; kinds[1] = INCR; kinds[2] = INCR; kinds[3] = WRAP; kinds[4] = RSVD;
    for (int i = 0; i < DEPTH; i++) model_valid[i] = 1'b0;
    bus.awvalid = 0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
    bus.awburst = '0; bus.awuser = '0;
    bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0;
    bus.arvalid = 0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
    bus.arburst = '0; bus.aruser = '0;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready_valid",
                data_t'({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}), '0);
    checkOutput("reset_ids_resp_user",
                data_t'({bus.bid, bus.rid, bus.bresp, bus.rresp, bus.buser, bus.ruser}), '0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] prefill whole array");
    write_burst(id_t'(1), addr_t'(0), 255, INCR, user_t'(0), 1, '0, 0, '1, -1, -1);
    drain();

    $display("[TB] incr write and readback at 0x40");
    write_burst(id_t'($urandom), addr_t'(32'h40), 3, INCR, user_t'(1), 1, '0, 0, '1, -1, -1);
    read_burst(id_t'($urandom), addr_t'(32'h40), 3, INCR, user_t'(1));
    drain();

    $display("[TB] byte strobes on word 0");
    write_burst(id_t'(2), addr_t'(0), 0, INCR, user_t'(0), 0, '0, 0, '1, -1, -1);
    write_burst(id_t'(3), addr_t'(0), 0, INCR, user_t'(0), 0, '1, 0, strb_t'(32'h0000000F), -1, -1);
    read_burst(id_t'(4), addr_t'(0), 0, INCR, user_t'(0));
    drain();

    $display("[TB] wrap and reserved bursts");
    write_burst(id_t'(5), addr_t'(32'h80), 1, WRAP, user_t'(1), 1, '0, 0, '1, -1, -1);
    read_burst(id_t'(6), addr_t'(32'h80), 1, INCR, user_t'(0));
    read_burst(id_t'(7), addr_t'(32'h80), 1, WRAP, user_t'(1));
    read_burst(id_t'(8), addr_t'(32'h80), 2, RSVD, user_t'(0));
    drain();

    $display("[TB] fixed burst and early wlast");
    write_burst(id_t'(9), addr_t'(32'hA0), 3, FIXED, user_t'(0), 1, '0, 1, '0, -1, -1);
    write_burst(id_t'(10), addr_t'(32'h300), 3, INCR, user_t'(1), 1, '0, 0, '1, 1, -1);
    read_burst(id_t'(11), addr_t'(32'hA0), 0, FIXED, user_t'(0));
    read_burst(id_t'(12), addr_t'(32'h300), 3, INCR, user_t'(0));
    drain();

    $display("[TB] read stall and response stall");
    fork
      read_burst(id_t'(13), addr_t'(32'h200), 7, INCR, user_t'(1));
      begin
        repeat (3) @(posedge clk);
        #1 bus.rready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.rready = 1'b1;
      end
    join
    drain();
    bus.bready = 1'b0;
    write_burst(id_t'(14), addr_t'(32'h20), 1, INCR, user_t'(0), 1, '0, 0, '1, -1, -1);
    repeat (5) @(posedge clk);
    #1 bus.bready = 1'b1;
    drain();

    $display("[TB] concurrent 16-beat write and read");
    r_beats = 0;
    w_wait_cycles = 0;
    fork
      write_burst(id_t'(15), addr_t'(32'h1000), 15, INCR, user_t'(0), 1, '0, 0, '1, -1, -1);
      read_burst(id_t'(16), addr_t'(32'h0), 15, INCR, user_t'(1));
    join
    drain();
    checkOutput("r_beat_count", data_t'(r_beats), data_t'(16));
    checkOutput("r_16_beats_in_16_cycles", data_t'(r_last_cyc - r_first_cyc), data_t'(15));
    checkOutput("w_no_stall_cycles", data_t'(w_wait_cycles), data_t'(0));

    $display("[TB] index wrap and address aliasing");
    write_burst(id_t'(17), addr_t'(32'hABC0_1FE0), 1, INCR, user_t'(1), 1, '0, 0, '1, -1, -1);
    read_burst(id_t'(18), addr_t'(32'h1FE0), 0, INCR, user_t'(0));
    read_burst(id_t'(19), addr_t'(32'h5000_0000), 0, INCR, user_t'(1));
    drain();

    $display("[TB] random bursts");
    for (int i = 0; i < 24; i++) begin
      bt = kinds[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 0)
        write_burst(id_t'($urandom), addr_t'($urandom), $urandom_range(0, 7), bt, user_t'($urandom),
                    1, '0, 1'($urandom_range(0, 1)), '1, -1, -1);
      else
        read_burst(id_t'($urandom), addr_t'($urandom), $urandom_range(0, 7), bt, user_t'($urandom));
      drain();
    end

    $display("[TB] reset on write beat 2 of 4");
    write_burst(id_t'(20), addr_t'(32'h600), 3, INCR, user_t'(0), 1, '0, 0, '1, -1, 2);
    read_burst(id_t'(21), addr_t'(32'h600), 3, INCR, user_t'(0));
    drain();

    checkOutput("scoreboard_empty", data_t'(b_q.size() + r_q.size()), '0);
  endtask

  initial begin
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
